alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle instruction sequencer for the ALU datapath.
- Fetches 16-bit instructions over a req/ack memory handshake, decodes them, and drives the datapath control bundle (immediate, imm_control, control1, control2, opcode, buff_en, enable).
- Handles register writeback, relative jumps, halt, and fetch timeout.
- Replaces the free-running fsm_sum pattern generator as the datapath's master.

Parameters:
- RESET_PC, 16'h0000, fetch address loaded at reset.
- FETCH_TIMEOUT, 255, max cycles in FETCH without imem_ack before error halt (1..65535).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; begins execution from current PC when IDLE.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  16  fetch address (= PC).
- imem_ack  input  1  fetch data valid this cycle.
- imem_rdata  input  16  instruction word.
- immediate  output  16  sign-extended imm8 to datapath.
- imm_control  output  1  1 = ALU B operand from immediate.
- control1  output  5  operand A register select.
- control2  output  5  operand B register select.
- opcode  output  8  ALU opcode.
- buff_en  output  1  ALU result drive onto bus.
- enable  output  16  one-hot register write enable.
- busy  output  1  high in FETCH/DECODE/EXECUTE.
- halted  output  1  high in HALT.
- error  output  1  sticky; set on fetch timeout.

Behaviour:
- Instruction format: [15:12] op, [11:8] rd, [7:4] ext or imm[7:4], [3:0] rs or imm[3:0].
- Reset (synchronous):
  - State = IDLE, PC = RESET_PC, timeout counter = 0.
  - All outputs 0, except imem_addr = RESET_PC.
  - Reset mid-operation aborts on the same edge; enable and buff_en are 0 from the next cycle.
- IDLE:
  - start=1 → FETCH. Otherwise stay.
  - start in any other state is ignored.
- FETCH:
  - imem_req=1 held every cycle until ack.
  - On imem_ack=1: latch IR = imem_rdata, clear counter, → DECODE.
  - Without ack, counter increments. When counter reaches FETCH_TIMEOUT-1 with no ack: error=1, → HALT, imem_req=0.
  - imem_ack outside FETCH is ignored.
- DECODE (1 cycle): registered control outputs update at the end of this cycle.
  - op=4'h0 (register ALU): opcode={4'h0,ext}, control1={1'b0,rd}, control2={1'b0,rs}, imm_control=0 → EXECUTE.
  - op=4'hC (jump): PC = PC + signext(imm8), mod 2^16. No datapath outputs change → FETCH.
  - op=4'hF (halt): → HALT.
  - Any other op (immediate ALU): opcode={op,4'h0}, control1={1'b0,rd}, control2=0, immediate={{8{imm[7]}},imm8}, imm_control=1 → EXECUTE.
- EXECUTE (1 cycle):
  - buff_en=1.
  - enable = 16'h1 << rd, except compare (op=4'hB, or op=4'h0 with ext=4'hB), where enable=0.
  - PC = PC+1 (16'hFFFF wraps to 16'h0000) → FETCH.
- Output hold rules:
  - buff_en and enable are nonzero only in EXECUTE.
  - immediate, imm_control, control1/2 and opcode hold their last decoded value outside DECODE/EXECUTE.
- HALT:
  - imem_req=0, busy=0, halted=1.
  - Stays until reset; start is ignored.
- Latency:
  - Zero-wait ALU instruction = 3 cycles (FETCH, DECODE, EXECUTE).
  - Jump = 2 cycles.
  - Each wait state adds 1 cycle.

Test Plan:
- Reset, start; memory acks immediately with 16'h0312 at addr 0 (ext=1, rd=3, rs=2) → DECODE: opcode=8'h01, control1=3, control2=2, imm_control=0. EXECUTE: enable=16'h0008, buff_en=1 for exactly 1 cycle; imem_addr=1 in the next FETCH.
- Instruction 16'h54FE at PC 5 → immediate=16'hFFFE, imm_control=1, opcode=8'h50, enable=16'h0010. Then 16'hB312 → enable=0, buff_en=1.
- Jump 16'hC0FD at PC=2 → next imem_addr=16'hFFFF. Then an ALU op there → next imem_addr=16'h0000.
- Ack delayed 4 cycles → imem_req high for all 5 FETCH cycles. With FETCH_TIMEOUT=8 and no ack → error=1 and halted=1 after 8 FETCH cycles.
- 16'hF000 → halted=1, busy=0; further start pulses leave imem_req=0 until reset.
- Assert reset during EXECUTE (enable nonzero) → next cycle all outputs 0, imem_addr=RESET_PC, state IDLE. A subsequent start refetches from RESET_PC.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: start/status, instruction-fetch handshake and datapath control bundle of the sequencer.
interface alu_sequencer_if;
   logic        start;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] immediate;
   logic        imm_control;
   logic [4:0]  control1;
   logic [4:0]  control2;
   logic [7:0]  opcode;
   logic        buff_en;
   logic [15:0] enable;
   logic        busy;
   logic        halted;
   logic        error;
   modport master (
      input  start, imem_ack, imem_rdata,
      output imem_req, imem_addr, immediate, imm_control, control1, control2,
             opcode, buff_en, enable, busy, halted, error
   );
   modport slave (
      output start, imem_ack, imem_rdata,
      input  imem_req, imem_addr, immediate, imm_control, control1, control2,
             opcode, buff_en, enable, busy, halted, error
   );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches 16-bit instructions over req/ack, decodes them and drives the ALU datapath controls.
module alu_sequencer #(
   parameter logic [15:0] RESET_PC      = 16'h0000,
   parameter int unsigned FETCH_TIMEOUT = 255
) (
   input logic            clk,
   input logic            reset,
   alu_sequencer_if.master io
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, HALT} state_e;
   localparam logic [15:0] TMO_LAST = 16'(FETCH_TIMEOUT - 1);
   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d, ir_q, ir_d, cnt_q, cnt_d, imm_q, imm_d, en_q, en_d;
   logic [7:0]  opc_q, opc_d;
   logic [4:0]  c1_q, c1_d, c2_q, c2_d;
   logic        immc_q, immc_d, buf_q, buf_d, err_q, err_d;
   logic [3:0]  op, rd, ext, rs;
   logic [15:0] sext;
   assign op   = ir_q[15:12];
   assign rd   = ir_q[11:8];
   assign ext  = ir_q[7:4];
   assign rs   = ir_q[3:0];
   assign sext = {{8{ir_q[7]}}, ir_q[7:0]};
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      imm_d   = imm_q;
      immc_d  = immc_q;
      c1_d    = c1_q;
      c2_d    = c2_q;
      opc_d   = opc_q;
      err_d   = err_q;
      buf_d   = 1'b0;
      en_d    = '0;
      case (state_q)
         IDLE: state_d = io.start ? FETCH : IDLE;
         FETCH: begin
            if (io.imem_ack) begin
               ir_d    = io.imem_rdata;
               cnt_d   = '0;
               state_d = DECODE;
            end else if (cnt_q == TMO_LAST) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = HALT;
            end else begin
               cnt_d = cnt_q + 16'h1;
            end
         end
         DECODE: begin
            if (op == 4'hC) begin
               pc_d    = pc_q + sext;
               state_d = FETCH;
            end else if (op == 4'hF) begin
               state_d = HALT;
            end else begin
               // Write enable and bus drive are registered here so they are live exactly during EXECUTE.
               opc_d   = (op == 4'h0) ? {4'h0, ext} : {op, 4'h0};
               c1_d    = {1'b0, rd};
               c2_d    = (op == 4'h0) ? {1'b0, rs} : 5'd0;
               immc_d  = (op != 4'h0);
               imm_d   = (op == 4'h0) ? imm_q : sext;
               buf_d   = 1'b1;
               en_d    = (op == 4'hB || (op == 4'h0 && ext == 4'hB)) ? 16'h0 : 16'h1 << rd;
               state_d = EXECUTE;
            end
         end
         EXECUTE: begin
            pc_d    = pc_q + 16'h1;
            state_d = FETCH;
         end
         default: state_d = state_q;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         cnt_q   <= '0;
         imm_q   <= '0;
         immc_q  <= 1'b0;
         c1_q    <= '0;
         c2_q    <= '0;
         opc_q   <= '0;
         buf_q   <= 1'b0;
         en_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
         imm_q   <= imm_d;
         immc_q  <= immc_d;
         c1_q    <= c1_d;
         c2_q    <= c2_d;
         opc_q   <= opc_d;
         buf_q   <= buf_d;
         en_q    <= en_d;
         err_q   <= err_d;
      end
   end
   assign io.imem_req    = (state_q == FETCH);
   assign io.imem_addr   = pc_q;
   assign io.immediate   = imm_q;
   assign io.imm_control = immc_q;
   assign io.control1    = c1_q;
   assign io.control2    = c2_q;
   assign io.opcode      = opc_q;
   assign io.buff_en     = buf_q;
   assign io.enable      = en_q;
   assign io.busy        = (state_q == FETCH) || (state_q == DECODE) || (state_q == EXECUTE);
   assign io.halted      = (state_q == HALT);
   assign io.error       = err_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random instruction streams checked against an instruction-level model.
module tb_alu_sequencer;
   logic clk, reset;
   int   n_chk, n_fail;
   logic [15:0] m_pc, m_imm;
   logic [7:0]  m_opc;
   logic [4:0]  m_c1, m_c2;
   logic        m_immc;
   alu_sequencer_if io();
   alu_sequencer #(.RESET_PC(16'h0000), .FETCH_TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .io(io.master)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_ctl();
      chk("ctl_opcode", {8'h0, io.opcode}, {8'h0, m_opc});
      chk("ctl_control1", {11'h0, io.control1}, {11'h0, m_c1});
      chk("ctl_control2", {11'h0, io.control2}, {11'h0, m_c2});
      chk("ctl_immediate", io.immediate, m_imm);
      chk("ctl_imm_control", {15'h0, io.imm_control}, {15'h0, m_immc});
   endtask
   task automatic model_reset();
      m_pc = 16'h0000; m_imm = '0; m_opc = '0; m_c1 = '0; m_c2 = '0; m_immc = 1'b0;
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_req"}, {15'h0, io.imem_req}, 16'h0);
      chk({tag, "_addr"}, io.imem_addr, 16'h0000);
      chk({tag, "_buff_en"}, {15'h0, io.buff_en}, 16'h0);
      chk({tag, "_enable"}, io.enable, 16'h0);
      chk({tag, "_busy"}, {15'h0, io.busy}, 16'h0);
      chk({tag, "_halted"}, {15'h0, io.halted}, 16'h0);
      chk({tag, "_error"}, {15'h0, io.error}, 16'h0);
      chk_ctl();
   endtask
   task automatic pulse_start();
      io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
   endtask
   // Entered at the first FETCH cycle; returns at the first cycle after the instruction completes.
   task automatic exec(input logic [15:0] ins, input int waits);
      logic [3:0]  op, rd, ext;
      logic [15:0] sx;
      op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4];
      sx = {{8{ins[7]}}, ins[7:0]};
      for (int i = 0; i <= waits; i++) begin
         chk("fetch_req", {15'h0, io.imem_req}, 16'h1);
         chk("fetch_addr", io.imem_addr, m_pc);
         chk("fetch_buff_en", {15'h0, io.buff_en}, 16'h0);
         chk("fetch_enable", io.enable, 16'h0);
         chk("fetch_busy", {15'h0, io.busy}, 16'h1);
         io.imem_ack   = (i == waits);
         io.imem_rdata = (i == waits) ? ins : 16'($urandom);
         @(negedge clk);
      end
      io.imem_ack   = 1'b1;
      io.imem_rdata = 16'hF000;
      chk("dec_req", {15'h0, io.imem_req}, 16'h0);
      chk("dec_busy", {15'h0, io.busy}, 16'h1);
      chk("dec_buff_en", {15'h0, io.buff_en}, 16'h0);
      chk("dec_enable", io.enable, 16'h0);
      @(negedge clk);
      io.imem_ack = 1'b0;
      if (op == 4'hC) begin
         m_pc = m_pc + sx;
      end else if (op == 4'hF) begin
         chk("halt_halted", {15'h0, io.halted}, 16'h1);
         chk("halt_busy", {15'h0, io.busy}, 16'h0);
         chk("halt_req", {15'h0, io.imem_req}, 16'h0);
      end else begin
         m_opc  = (op == 4'h0) ? {4'h0, ext} : {op, 4'h0};
         m_c1   = {1'b0, rd};
         m_c2   = (op == 4'h0) ? {1'b0, ins[3:0]} : 5'd0;
         m_immc = (op != 4'h0);
         if (op != 4'h0) m_imm = sx;
         chk("exe_buff_en", {15'h0, io.buff_en}, 16'h1);
         chk("exe_enable", io.enable,
             (op == 4'hB || (op == 4'h0 && ext == 4'hB)) ? 16'h0 : (16'h1 << rd));
         chk("exe_busy", {15'h0, io.busy}, 16'h1);
         chk_ctl();
         @(negedge clk);
         m_pc = m_pc + 16'h1;
      end
      chk_ctl();
   endtask
   initial begin
      logic [15:0] ins;
      n_chk = 0; n_fail = 0;
      io.start = 1'b0; io.imem_ack = 1'b0; io.imem_rdata = '0;
      reset = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      chk_reset("rst");
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", {15'h0, io.busy}, 16'h0);
      pulse_start();
      exec(16'h0312, 0);
      exec(16'hC004, 0);
      exec(16'h54FE, 0);
      exec(16'hB312, 0);
      exec(16'hC0FB, 0);
      exec(16'hC0FD, 0);
      exec(16'h0312, 0);
      exec(16'h0B45, 0);
      exec(16'h1234, 4);
      exec(16'h2345, 7);
      for (int k = 0; k < 40; k++) begin
         ins = {4'($urandom_range(0, 14)), 12'($urandom)};
         exec(ins, int'($urandom_range(0, 3)));
      end
      exec(16'hF000, 0);
      repeat (3) begin
         pulse_start();
         chk("halt_start_req", {15'h0, io.imem_req}, 16'h0);
         chk("halt_start_halted", {15'h0, io.halted}, 16'h1);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      chk_reset("rst_halt");
      pulse_start();
      exec(16'h0742, 0);
      chk("pre_exec_addr", io.imem_addr, 16'h0001);
      io.imem_ack = 1'b1; io.imem_rdata = 16'h0512;
      @(negedge clk);
      io.imem_ack = 1'b0;
      @(negedge clk);
      chk("mid_exec_enable", io.enable, 16'h0020);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      chk_reset("rst_exec");
      pulse_start();
      exec(16'h0312, 0);
      for (int i = 0; i < 8; i++) begin
         chk("tmo_req", {15'h0, io.imem_req}, 16'h1);
         chk("tmo_error_early", {15'h0, io.error}, 16'h0);
         @(negedge clk);
      end
      chk("tmo_error", {15'h0, io.error}, 16'h1);
      chk("tmo_halted", {15'h0, io.halted}, 16'h1);
      chk("tmo_req_off", {15'h0, io.imem_req}, 16'h0);
      chk("tmo_busy", {15'h0, io.busy}, 16'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
